updown_mod_counter: RTL and testbench

Parametrised synchronous up/down counter with programmable modulus, wrap or saturate behaviour, count enable, parallel load, and terminal-event flags. It is the general-purpose successor to the fixed 4-bit up/down counter. Timers, address sequencers and event counters instantiate it wherever they need a bounded count range with overflow reporting.

---
 rtl/updown_mod_counter.sv | 73 +++++++
 tb/tb_updown_mod_counter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Parametrised up/down counter over 0..max_val with wrap or saturate at the bounds,
// parallel load, and a terminal-event pulse plus sticky overflow flag.
module updown_mod_counter #(
    parameter int unsigned WIDTH = 8,
    parameter bit          SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [WIDTH-1:0] max_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             tc,
    output logic             ovf_sticky
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             term;
    logic             tc_q;
    logic             ovf_q;

    always_comb begin
        count_d = count_q;
        term    = 1'b0;
        if (load) begin
            count_d = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            if (!dir) begin
                if (count_q >= max_val) begin
                    term    = 1'b1;
                    count_d = SAT ? max_val : '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                // A count stranded above a lowered bound is pulled back without an event.
                if (count_q > max_val) begin
                    count_d = max_val;
                end else if (count_q == '0) begin
                    term    = 1'b1;
                    count_d = SAT ? '0 : max_val;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= term;
            ovf_q   <= term | (ovf_q & ~clr_flags);
        end
    end

    assign count      = count_q;
    assign tc         = tc_q;
    assign ovf_sticky = ovf_q;
    assign at_max     = (count_q == max_val);
    assign at_min     = (count_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: directed steps push expected results, a monitor pops and compares.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       dir = 1'b0;
    logic [3:0] max_val = 4'd9;
    logic       clr_flags = 1'b0;

    logic [3:0] count_w, count_s;
    logic       at_max_w, at_min_w, tc_w, ovf_w;
    logic       at_max_s, at_min_s, tc_s, ovf_s;

    updown_mod_counter #(.WIDTH(4), .SAT(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .dir(dir),
        .max_val(max_val), .clr_flags(clr_flags), .count(count_w), .at_max(at_max_w),
        .at_min(at_min_w), .tc(tc_w), .ovf_sticky(ovf_w)
    );

    updown_mod_counter #(.WIDTH(4), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .dir(dir),
        .max_val(max_val), .clr_flags(clr_flags), .count(count_s), .at_max(at_max_s),
        .at_min(at_min_s), .tc(tc_s), .ovf_sticky(ovf_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       sel;     // 0 = wrap instance, 1 = saturate instance
        string    name;
        bit [3:0] cnt;
        bit       tc;
        bit       ovf;
        bit       amax;
        bit       amin;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input string field, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, exp);
        end
    endtask

    task automatic step(input bit s, input string name, input bit r, input bit ld,
                        input logic [3:0] lv, input bit e, input bit d, input logic [3:0] mx,
                        input bit c, input logic [3:0] ec, input bit et, input bit eo);
        exp_t x;
        @(negedge clk);
        rst = r; load = ld; load_val = lv; en = e; dir = d; max_val = mx; clr_flags = c;
        x.sel = s; x.name = name; x.cnt = ec; x.tc = et; x.ovf = eo;
        x.amax = (ec == mx); x.amin = (ec == 4'd0);
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                x = q.pop_front();
                if (!x.sel) begin
                    chk(x.name, "count", int'(count_w), int'(x.cnt));
                    chk(x.name, "tc", int'(tc_w), int'(x.tc));
                    chk(x.name, "ovf", int'(ovf_w), int'(x.ovf));
                    chk(x.name, "at_max", int'(at_max_w), int'(x.amax));
                    chk(x.name, "at_min", int'(at_min_w), int'(x.amin));
                end else begin
                    chk(x.name, "count", int'(count_s), int'(x.cnt));
                    chk(x.name, "tc", int'(tc_s), int'(x.tc));
                    chk(x.name, "ovf", int'(ovf_s), int'(x.ovf));
                    chk(x.name, "at_max", int'(at_max_s), int'(x.amax));
                    chk(x.name, "at_min", int'(at_min_s), int'(x.amin));
                end
            end
        end
    end

    initial begin : stimulus
        int unsigned n;
        bit [3:0] up_cnt [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};

        // wrap-mode up count 0..9 and roll to 0
        step(0, "reset", 1, 0, 4'd0, 0, 0, 4'd9, 0, 4'd0, 0, 0);
        for (int i = 0; i < 12; i++)
            step(0, "up_wrap", 0, 0, 4'd0, 1, 0, 4'd9, 0, up_cnt[i], (i == 9), (i >= 9));

        // saturate-mode down count parks at 0
        step(1, "sat_rst", 1, 0, 4'd0, 0, 0, 4'd9, 0, 4'd0, 0, 0);
        step(1, "sat_load", 0, 1, 4'd2, 0, 1, 4'd9, 0, 4'd2, 0, 0);
        step(1, "sat_dn1", 0, 0, 4'd0, 1, 1, 4'd9, 0, 4'd1, 0, 0);
        step(1, "sat_dn0", 0, 0, 4'd0, 1, 1, 4'd9, 0, 4'd0, 0, 0);
        step(1, "sat_dnA", 0, 0, 4'd0, 1, 1, 4'd9, 0, 4'd0, 1, 1);
        step(1, "sat_dnB", 0, 0, 4'd0, 1, 1, 4'd9, 0, 4'd0, 1, 1);

        // load clamp and load priority over en
        step(1, "load_clamp", 0, 1, 4'd15, 0, 0, 4'd9, 0, 4'd9, 0, 1);
        step(1, "load_vs_en", 0, 1, 4'd3, 1, 0, 4'd9, 0, 4'd3, 0, 1);

        // saturate at top
        step(1, "sat_rst2", 1, 0, 4'd0, 0, 0, 4'd9, 0, 4'd0, 0, 0);
        step(1, "sat_ld9", 0, 1, 4'd9, 0, 0, 4'd9, 0, 4'd9, 0, 0);
        step(1, "sat_top", 0, 0, 4'd0, 1, 0, 4'd9, 0, 4'd9, 1, 1);

        // lowered bound under a live count, then max_val = 0
        step(0, "mv_rst", 1, 0, 4'd0, 0, 0, 4'd9, 0, 4'd0, 0, 0);
        step(0, "mv_load7", 0, 1, 4'd7, 0, 1, 4'd9, 0, 4'd7, 0, 0);
        step(0, "mv_pull", 0, 0, 4'd0, 1, 1, 4'd4, 0, 4'd4, 0, 0);
        step(0, "mv_dn3", 0, 0, 4'd0, 1, 1, 4'd4, 0, 4'd3, 0, 0);
        step(0, "mv_dn2", 0, 0, 4'd0, 1, 1, 4'd4, 0, 4'd2, 0, 0);
        step(0, "m0_pull", 0, 0, 4'd0, 1, 1, 4'd0, 0, 4'd0, 0, 0);
        step(0, "m0_dn", 0, 0, 4'd0, 1, 1, 4'd0, 0, 4'd0, 1, 1);
        step(0, "m0_up", 0, 0, 4'd0, 1, 0, 4'd0, 0, 4'd0, 1, 1);
        step(0, "m0_dn2", 0, 0, 4'd0, 1, 1, 4'd0, 0, 4'd0, 1, 1);

        // sticky clear, and terminal event beating clear
        step(0, "clr", 0, 0, 4'd0, 0, 0, 4'd0, 1, 4'd0, 0, 0);
        step(0, "clr_vs_ev", 0, 0, 4'd0, 1, 0, 4'd0, 1, 4'd0, 1, 1);
        step(0, "hold_ovf", 0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0, 1);

        // reset beats load, then hold with en low
        step(0, "ld5", 0, 1, 4'd5, 0, 0, 4'd9, 0, 4'd5, 0, 1);
        step(0, "rst_vs_ld", 1, 1, 4'd8, 1, 0, 4'd9, 0, 4'd0, 0, 0);
        step(0, "ld5b", 0, 1, 4'd5, 0, 0, 4'd9, 0, 4'd5, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, "hold", 0, 0, 4'd0, 0, 1, 4'd9, 0, 4'd5, 0, 0);

        // wrap-mode down from 0 wraps to max
        step(0, "dn_rst", 1, 0, 4'd0, 0, 0, 4'd9, 0, 4'd0, 0, 0);
        step(0, "dn_wrap", 0, 0, 4'd0, 1, 1, 4'd9, 0, 4'd9, 1, 1);
        step(0, "dn_8", 0, 0, 4'd0, 1, 1, 4'd9, 0, 4'd8, 0, 1);

        @(negedge clk);
        en = 1'b0; load = 1'b0; rst = 1'b0; clr_flags = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
